// File: rtl/phys_free_list_pkg.sv
// ----------------------------------------------------------------------------
// phys_free_list_pkg
//   Shared sizing constants, the commit-release record and the free-list FSM
//   state encoding for the physical register free list.
//   No ports (package).
// ----------------------------------------------------------------------------
package phys_free_list_pkg;

    localparam int NUM_PHYS_REG = 64;  // total physical registers (power of 2)
    localparam int NUM_ARCH_REG = 16;  // tags 0..NUM_ARCH_REG-1 start mapped
    localparam int FL_CAP       = NUM_PHYS_REG - NUM_ARCH_REG;
    localparam int TAG_W        = $clog2(NUM_PHYS_REG);
    localparam int PTR_W        = TAG_W + 1;  // MSB is the wrap bit

    // One commit-stage release: the old mapping of a committing destination.
    typedef struct packed {
        logic             dst_v;
        logic [TAG_W-1:0] old_phys;
    } commit_rename_s;

    localparam int COMMIT_RENAME_WIDTH = $bits(commit_rename_s);

    typedef enum logic {
        FL_INIT,
        FL_RUN
    } fl_state_e;

endpackage

// File: rtl/phys_free_list_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// phys_free_list_ptr_ctrl (fl_ptr_ctrl)
//   Head / commit-head / tail pointer registers of the circular free list and
//   the occupancy count derived from them.
// Ports:
//   clk_i, reset_i          clock, synchronous active-low reset
//   init_i                  INIT fill step: tail advances, nothing else moves
//   alloc_i                 allocation fired: head advances
//   push_i                  release accepted into storage: tail advances
//   commit_i                release seen (dst_v): commit head advances
//   mispredict_i            restore head from the updated commit head
//   head_o, commit_head_next_o, tail_o   pointers (wrap bit in MSB)
//   count_o                 tail - head
// ----------------------------------------------------------------------------
module phys_free_list_ptr_ctrl
    import phys_free_list_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             init_i,
    input  logic             alloc_i,
    input  logic             push_i,
    input  logic             commit_i,
    input  logic             mispredict_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] commit_head_next_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [PTR_W-1:0] count_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] commit_head_q, commit_head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    always_comb begin
        head_d        = head_q;
        commit_head_d = commit_head_q;
        tail_d        = tail_q;
        if (init_i) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            commit_head_d = commit_head_q + PTR_W'(commit_i);
            tail_d        = tail_q + PTR_W'(push_i);
            // The mispredicting instruction commits this cycle, so the
            // restored head already includes its commit-head increment.
            if (mispredict_i) begin
                head_d = commit_head_d;
            end else if (alloc_i) begin
                head_d = head_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
        end else begin
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

    assign head_o             = head_q;
    assign commit_head_next_o = commit_head_d;
    assign tail_o             = tail_q;
    // Modular subtraction in pointer width gives the occupancy across wraps.
    assign count_o            = tail_q - head_q;

endmodule

// File: rtl/phys_free_list.sv
// ----------------------------------------------------------------------------
// phys_free_list
//   Circular free list of physical register tags. Filled with tags
//   NUM_ARCH_REG..NUM_PHYS_REG-1 after reset, hands tags to rename through a
//   valid/ready handshake, takes back old mappings from commit, and restores
//   the speculative head from the committed head on a mispredict.
//
//   Handshake: fl_alloc_ready_o means fl_alloc_reg_o holds a free tag; a tag
//   is consumed on a clock edge where rename_alloc_v_i && fl_alloc_ready_o.
//   Ready never depends on rename_alloc_v_i.
//
//   Optional: define FREE_LIST_CHECK_EN to track per-tag membership and flag
//   duplicate frees on fl_dup_err_o (tied 0 otherwise).
// Ports:
//   clk_i, reset_i         clock, synchronous active-low reset
//   rename_alloc_v_i       rename wants a tag this cycle
//   fl_alloc_ready_o       a tag is available
//   fl_alloc_reg_o         tag at the head
//   rob_rename_valid_i     commit release valid
//   rob_rename_entry_i     packed commit_rename_s {dst_v, old_phys}
//   rob_mispredict_i       flush: restore the speculative head
//   fl_count_o             free count (tail - head)
//   fl_overflow_err_o      sticky: release dropped because the list was full
//   fl_dup_err_o           sticky: duplicate free
//   dbg_state_o            FSM state for observation
// ----------------------------------------------------------------------------
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           rename_alloc_v_i,
    output logic                           fl_alloc_ready_o,
    output logic [TAG_W-1:0]               fl_alloc_reg_o,
    input  logic                           rob_rename_valid_i,
    input  logic [COMMIT_RENAME_WIDTH-1:0] rob_rename_entry_i,
    input  logic                           rob_mispredict_i,
    output logic [PTR_W-1:0]               fl_count_o,
    output logic                           fl_overflow_err_o,
    output logic                           fl_dup_err_o,
    output fl_state_e                      dbg_state_o
);

    fl_state_e        state_q;
    logic [PTR_W-1:0] init_cnt_q;
    logic             ovf_q;
    logic [TAG_W-1:0] mem_q [NUM_PHYS_REG];

    logic [PTR_W-1:0] head, commit_head_next, tail, count;
    commit_rename_s   entry;
    logic             in_init, in_run, alloc_fire, release_v, push, misp;

    assign entry      = commit_rename_s'(rob_rename_entry_i);
    assign in_init    = (state_q == FL_INIT);
    assign in_run     = (state_q == FL_RUN);
    assign misp       = in_run && rob_mispredict_i;
    assign fl_alloc_ready_o = in_run && (count != '0) && !rob_mispredict_i;
    assign alloc_fire = rename_alloc_v_i && fl_alloc_ready_o;
    assign release_v  = in_run && rob_rename_valid_i && entry.dst_v;
    // Fullness is judged on the count before this cycle's allocation.
    assign push       = release_v && (count < PTR_W'(FL_CAP));

    phys_free_list_ptr_ctrl u_ptr (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .init_i             (in_init),
        .alloc_i            (alloc_fire),
        .push_i             (push),
        .commit_i           (release_v),
        .mispredict_i       (misp),
        .head_o             (head),
        .commit_head_next_o (commit_head_next),
        .tail_o             (tail),
        .count_o            (count)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= FL_INIT;
            init_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                FL_INIT: begin
                    init_cnt_q <= init_cnt_q + PTR_W'(1);
                    if (init_cnt_q == PTR_W'(FL_CAP - 1)) begin
                        state_q <= FL_RUN;
                    end
                end
                FL_RUN: begin
                    if (release_v && !push) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: state_q <= FL_INIT;
            endcase
        end
    end

    // Storage carries no reset; INIT rewrites every entry that can be read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (in_init) begin
                mem_q[tail[TAG_W-1:0]] <= TAG_W'(NUM_ARCH_REG) + init_cnt_q[TAG_W-1:0];
            end else if (push) begin
                mem_q[tail[TAG_W-1:0]] <= entry.old_phys;
            end
        end
    end

    assign fl_alloc_reg_o    = in_run ? mem_q[head[TAG_W-1:0]] : '0;
    assign fl_count_o        = count;
    assign fl_overflow_err_o = ovf_q;
    assign dbg_state_o       = state_q;

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PHYS_REG-1:0] in_list_q, in_list_d;
    logic                    dup_q, dup_set;
    logic [PTR_W-1:0]        span;
    logic [TAG_W-1:0]        off;

    // Entries in [commit_head_next, head) were handed out speculatively and
    // return to the list on a mispredict.
    assign span = head - commit_head_next;

    always_comb begin
        in_list_d = in_list_q;
        dup_set   = 1'b0;
        off       = '0;
        if (alloc_fire) begin
            in_list_d[fl_alloc_reg_o] = 1'b0;
        end
        if (push) begin
            dup_set                 = in_list_q[entry.old_phys];
            in_list_d[entry.old_phys] = 1'b1;
        end
        if (misp && (span <= PTR_W'(NUM_PHYS_REG))) begin
            for (int i = 0; i < NUM_PHYS_REG; i++) begin
                off = TAG_W'(i) - commit_head_next[TAG_W-1:0];
                if ({1'b0, off} < span) begin
                    in_list_d[mem_q[i]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            in_list_q <= {{FL_CAP{1'b1}}, {NUM_ARCH_REG{1'b0}}};
            dup_q     <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            if (dup_set) begin
                dup_q <= 1'b1;
            end
        end
    end

    assign fl_dup_err_o = dup_q;
`else
    assign fl_dup_err_o = 1'b0;
`endif

    // Wrap bits and the commit-head view only matter to the membership check.
    logic unused_ptr_bits;
    assign unused_ptr_bits = head[TAG_W] ^ tail[TAG_W] ^ (^commit_head_next);

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic                           clk;
  logic                           reset_i;
  logic                           rename_alloc_v_i;
  logic                           fl_alloc_ready_o;
  logic [TAG_W-1:0]               fl_alloc_reg_o;
  logic                           rob_rename_valid_i;
  logic [COMMIT_RENAME_WIDTH-1:0] rob_rename_entry_i;
  logic                           rob_mispredict_i;
  logic [PTR_W-1:0]               fl_count_o;
  logic                           fl_overflow_err_o;
  logic                           fl_dup_err_o;
  fl_state_e                      dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [TAG_W-1:0] exp_q[$];    // expected tags, one per requested allocation
  logic [TAG_W-1:0] model_q[$];  // golden FIFO of the list contents

  phys_free_list dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .rename_alloc_v_i   (rename_alloc_v_i),
    .fl_alloc_ready_o   (fl_alloc_ready_o),
    .fl_alloc_reg_o     (fl_alloc_reg_o),
    .rob_rename_valid_i (rob_rename_valid_i),
    .rob_rename_entry_i (rob_rename_entry_i),
    .rob_mispredict_i   (rob_mispredict_i),
    .fl_count_o         (fl_count_o),
    .fl_overflow_err_o  (fl_overflow_err_o),
    .fl_dup_err_o       (fl_dup_err_o),
    .dbg_state_o        (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every requested allocation must be accepted and carry the
  // tag the scoreboard predicted.
  always @(negedge clk) begin
    if (reset_i && rename_alloc_v_i) begin
      n_cmp++;
      if (fl_alloc_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL alloc_ready: got %0d expected 1", fl_alloc_ready_o);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL alloc_unexpected: got %0d expected none", fl_alloc_reg_o);
      end else begin
        logic [TAG_W-1:0] e;
        e = exp_q.pop_front();
        if (fl_alloc_reg_o !== e) begin
          n_fail++;
          $display("FAIL alloc_tag: got %0d expected %0d", fl_alloc_reg_o, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    rename_alloc_v_i = 1'b0;
    rob_rename_valid_i = 1'b0;
    rob_rename_entry_i = '0;
    rob_mispredict_i = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(fl_alloc_ready_o), 0);
    check("rst_count", 32'(fl_count_o), 0);
    check("rst_reg", 32'(fl_alloc_reg_o), 0);
    check("rst_state", 32'(dbg_state_o), 32'(FL_INIT));
    reset_i = 1'b1;
  endtask

  // Counts edges after reset release until ready rises (bounded).
  task automatic wait_ready(input string name);
    int edges;
    edges = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      edges++;
      if (fl_alloc_ready_o === 1'b1) break;
    end
    check(name, 32'(edges), 48);
  endtask

  task automatic alloc(input logic [TAG_W-1:0] exp);
    exp_q.push_back(exp);
    rename_alloc_v_i = 1'b1;
    tick();
    rename_alloc_v_i = 1'b0;
  endtask

  task automatic release_tag(input logic [TAG_W-1:0] tag, input logic dst_v);
    rob_rename_valid_i = 1'b1;
    rob_rename_entry_i = {dst_v, tag};
    tick();
    rob_rename_valid_i = 1'b0;
    rob_rename_entry_i = '0;
  endtask

  task automatic alloc_release(input logic [TAG_W-1:0] exp, input logic [TAG_W-1:0] tag);
    exp_q.push_back(exp);
    rename_alloc_v_i = 1'b1;
    rob_rename_valid_i = 1'b1;
    rob_rename_entry_i = {1'b1, tag};
    tick();
    rename_alloc_v_i = 1'b0;
    rob_rename_valid_i = 1'b0;
    rob_rename_entry_i = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [TAG_W-1:0] prev, e;

    // T1: reset, INIT fill, first allocations
    do_reset();
    wait_ready("init_edges");
    check("init_count", 32'(fl_count_o), 48);
    check("init_reg", 32'(fl_alloc_reg_o), 16);
    check("init_state", 32'(dbg_state_o), 32'(FL_RUN));
    alloc(6'd16);
    alloc(6'd17);
    check("two_alloc_count", 32'(fl_count_o), 46);

    // T2: drain, then release / simultaneous alloc+release
    for (int t = 18; t < 64; t++) alloc(TAG_W'(t));
    check("empty_ready", 32'(fl_alloc_ready_o), 0);
    check("empty_count", 32'(fl_count_o), 0);
    release_tag(6'd5, 1'b1);
    check("rel5_ready", 32'(fl_alloc_ready_o), 1);
    check("rel5_reg", 32'(fl_alloc_reg_o), 5);
    check("rel5_count", 32'(fl_count_o), 1);
    alloc_release(6'd5, 6'd7);
    check("pair_count", 32'(fl_count_o), 1);
    check("pair_reg", 32'(fl_alloc_reg_o), 7);
    release_tag(6'd9, 1'b0);
    check("nodst_count", 32'(fl_count_o), 1);

    // T3: mispredict restore from a fresh list
    do_reset();
    wait_ready("misp_init_edges");
    alloc(6'd16);
    alloc(6'd17);
    alloc(6'd18);
    rob_rename_valid_i = 1'b1;
    rob_rename_entry_i = {1'b1, 6'd2};
    rob_mispredict_i = 1'b1;
    #1;
    check("misp_ready_low", 32'(fl_alloc_ready_o), 0);
    tick();
    rob_rename_valid_i = 1'b0;
    rob_rename_entry_i = '0;
    rob_mispredict_i = 1'b0;
    check("misp_reg", 32'(fl_alloc_reg_o), 17);
    check("misp_count", 32'(fl_count_o), 48);
    alloc(6'd17);
    alloc(6'd18);
    check("post_misp_count", 32'(fl_count_o), 46);

    // T4: 200 alloc/release pairs through the wrap point
    for (int t = 19; t < 64; t++) model_q.push_back(TAG_W'(t));
    model_q.push_back(6'd2);
    prev = 6'd16;
    for (int k = 0; k < 200; k++) begin
      e = model_q.pop_front();
      alloc_release(e, prev);
      model_q.push_back(prev);
      prev = e;
    end
    check("wrap_count", 32'(fl_count_o), 46);
    check("wrap_ovf", 32'(fl_overflow_err_o), 0);
    check("wrap_dup", 32'(fl_dup_err_o), 0);

    // T5: fill to capacity, then an overflowing release
    release_tag(prev, 1'b1);
    model_q.push_back(prev);
    release_tag(6'd3, 1'b1);
    model_q.push_back(6'd3);
    check("full_count", 32'(fl_count_o), 48);
    check("full_ovf", 32'(fl_overflow_err_o), 0);
    release_tag(6'd9, 1'b1);
    check("ovf_set", 32'(fl_overflow_err_o), 1);
    check("ovf_count", 32'(fl_count_o), 48);
    tick();
    tick();
    check("ovf_sticky", 32'(fl_overflow_err_o), 1);
    e = model_q.pop_front();
    alloc(e);
    check("ovf_alloc_count", 32'(fl_count_o), 47);

`ifdef FREE_LIST_CHECK_EN
    // T6: duplicate free of a tag still in the list
    do_reset();
    wait_ready("dup_init_edges");
    alloc(6'd16);
    check("dup_clear", 32'(fl_dup_err_o), 0);
    release_tag(6'd20, 1'b1);
    check("dup_set", 32'(fl_dup_err_o), 1);
`endif

    // T7: reset in the middle of INIT restarts the fill
    do_reset();
    for (int k = 0; k < 20; k++) tick();
    check("midinit_ready", 32'(fl_alloc_ready_o), 0);
    do_reset();
    wait_ready("restart_edges");
    check("restart_reg", 32'(fl_alloc_reg_o), 16);
    check("restart_count", 32'(fl_count_o), 48);
    check("restart_ovf", 32'(fl_overflow_err_o), 0);

    tick();
    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
